frame_buffer_switcher: RTL and testbench

Triple-buffer index manager between a frame producer (camera or HSV render stage) and a frame consumer (HSV fetch stage or VGA composer) that share three SDRAM frame buffers. It hands the producer a buffer to write and the consumer a buffer to read, and swaps indices on frame boundaries. Consequently, neither side ever touches the other's buffer, and the consumer always gets the newest completed frame. It drives the `write_buffer` and `read_buffer` conduits (`buffer_port`, `buffer_vsync`), which the system exports to the pipeline stages and PIOs.

---
 rtl/frame_buffer_switcher.sv | 109 ++++++++++
 tb/tb_frame_buffer_switcher.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_switcher.sv
// Triple-buffer index manager; the dropped-frame counter exists only when FBS_DROP_COUNT_EN is defined.
// Outputs are registered with 1-cycle latency. There is no backpressure: vsync edges that arrive while disabled are lost.
module frame_buffer_switcher #(
    parameter int PORT_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              write_vsync,
    input  logic              read_vsync,
    output logic [PORT_W-1:0] write_port,
    output logic [PORT_W-1:0] read_port,
    output logic              fresh,
    output logic [CNT_W-1:0]  drop_count
);

    logic [PORT_W-1:0] w_q, w_d;
    logic [PORT_W-1:0] r_q, r_d;
    logic [PORT_W-1:0] p_q, p_d;
    logic              fresh_q, fresh_d;
    logic              wv_q, rv_q;
    logic              w_edge, r_edge;

    assign w_edge = write_vsync & ~wv_q;
    assign r_edge = read_vsync & ~rv_q;

    // Applying the write before the read gives the same net result as sequencing the two swaps.
    always_comb begin
        w_d     = w_q;
        r_d     = r_q;
        p_d     = p_q;
        fresh_d = fresh_q;
        if (enable) begin
            unique case ({w_edge, r_edge})
                2'b10: begin
                    w_d     = p_q;
                    p_d     = w_q;
                    fresh_d = 1'b1;
                end
                2'b01: begin
                    if (fresh_q) begin
                        r_d     = p_q;
                        p_d     = r_q;
                        fresh_d = 1'b0;
                    end
                end
                2'b11: begin
                    w_d     = p_q;
                    r_d     = w_q;
                    p_d     = r_q;
                    fresh_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The edge-detect registers track the inputs even while disabled, so a held level never re-fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q     <= PORT_W'(0);
            r_q     <= PORT_W'(1);
            p_q     <= PORT_W'(2);
            fresh_q <= 1'b0;
            wv_q    <= 1'b1;
            rv_q    <= 1'b1;
        end else begin
            w_q     <= w_d;
            r_q     <= r_d;
            p_q     <= p_d;
            fresh_q <= fresh_d;
            wv_q    <= write_vsync;
            rv_q    <= read_vsync;
        end
    end

`ifdef FBS_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             drop_inc;

    // A completed frame is lost whenever a new one lands while the pending frame is still unread.
    assign drop_inc = enable & w_edge & fresh_q;

    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

    assign write_port = w_q;
    assign read_port  = r_q;
    assign fresh      = fresh_q;

endmodule

// File: tb/tb_frame_buffer_switcher.sv
// Directed stimulus for frame_buffer_switcher with a reference-model scoreboard; CNT_W is reduced so saturation is reachable.
module tb_frame_buffer_switcher;

    localparam int PW = 2;
    localparam int CW = 4;
`ifdef FBS_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, write_vsync, read_vsync;
    logic [PW-1:0] write_port, read_port;
    logic          fresh;
    logic [CW-1:0] drop_count;

    always #5 clk = ~clk;

    frame_buffer_switcher #(.PORT_W(PW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .write_vsync(write_vsync),
        .read_vsync (read_vsync),
        .write_port (write_port),
        .read_port  (read_port),
        .fresh      (fresh),
        .drop_count (drop_count)
    );

    typedef struct packed {
        logic [PW-1:0] w;
        logic [PW-1:0] r;
        logic          f;
        logic [CW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] mw, mr, mp, tmp;
    logic          mf, mwv, mrv;
    logic [CW-1:0] md;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic en, input logic wv, input logic rv);
        logic we, re;
        if (rst) begin
            mw = 0; mr = 1; mp = 2; mf = 1'b0; md = '0; mwv = 1'b1; mrv = 1'b1;
        end else begin
            we = wv & ~mwv;
            re = rv & ~mrv;
            if (en && we) begin
                if (DROP_EN && mf && md != {CW{1'b1}}) md = md + 1'b1;
                tmp = mw; mw = mp; mp = tmp; mf = 1'b1;
            end
            if (en && re && mf) begin
                tmp = mr; mr = mp; mp = tmp; mf = 1'b0;
            end
            mwv = wv;
            mrv = rv;
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic wv, input logic rv);
        exp_t e;
        @(negedge clk);
        reset = rst; enable = en; write_vsync = wv; read_vsync = rv;
        model(rst, en, wv, rv);
        sb.push_back('{w: mw, r: mr, f: mf, d: md});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_write_port", write_port, e.w);
        check("sb_read_port", read_port, e.r);
        check("sb_fresh", fresh, e.f);
        check("sb_drop_count", drop_count, e.d);
        check("perm_distinct", (write_port != read_port) && (write_port < 3) && (read_port < 3), 1);
    endtask

    task automatic wpulse();
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; write_vsync = 1'b1; read_vsync = 1'b1;
        // Reset with both vsyncs high, then idle: no edge may appear.
        repeat (3) step(1, 1, 1, 1);
        check("rst_write_port", write_port, 0);
        check("rst_read_port", read_port, 1);
        check("rst_fresh", fresh, 0);
        check("rst_drop", drop_count, 0);
        repeat (10) step(0, 1, 1, 1);
        check("idle_write_port", write_port, 0);
        check("idle_read_port", read_port, 1);
        check("idle_fresh", fresh, 0);
        step(0, 1, 0, 0);

        // Read with nothing fresh keeps the same buffer.
        step(0, 1, 0, 1);
        check("stale_read_port", read_port, 1);
        check("stale_write_port", write_port, 0);
        check("stale_fresh", fresh, 0);
        step(0, 1, 0, 0);

        // Single write, then a read 5 cycles later.
        step(0, 1, 1, 0);
        check("w1_write_port", write_port, 2);
        check("w1_fresh", fresh, 1);
        repeat (4) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        check("r1_read_port", read_port, 0);
        check("r1_write_port", write_port, 2);
        check("r1_fresh", fresh, 0);
        step(0, 1, 0, 0);

        // Three writes, no read.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        wpulse();
        check("w3a_write_port", write_port, 2);
        wpulse();
        check("w3b_write_port", write_port, 0);
        wpulse();
        check("w3c_write_port", write_port, 2);
        check("w3_fresh", fresh, 1);
        check("w3_drop", drop_count, DROP_EN ? 2 : 0);

        // Simultaneous write and read edges from W=2,R=1,P=0,fresh=1.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        wpulse();
        step(0, 1, 1, 1);
        check("both_write_port", write_port, 0);
        check("both_read_port", read_port, 2);
        check("both_fresh", fresh, 0);
        check("both_drop", drop_count, DROP_EN ? 1 : 0);
        step(0, 1, 0, 0);

        // Edge while disabled is lost; re-enabling with vsync high does nothing.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        check("dis_write_port", write_port, 0);
        check("dis_fresh", fresh, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        check("reen_write_port", write_port, 2);
        check("reen_fresh", fresh, 1);
        step(0, 1, 0, 0);

        // Counter saturation: 18 writes give 17 drops on a 4-bit counter.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        repeat (18) wpulse();
        check("sat_drop", drop_count, DROP_EN ? 15 : 0);
        check("sat_fresh", fresh, 1);

        // Reset mid-frame with inputs high restores reset values and raises no edge.
        step(1, 1, 1, 1);
        step(0, 1, 1, 1);
        check("mid_write_port", write_port, 0);
        check("mid_read_port", read_port, 1);
        check("mid_fresh", fresh, 0);
        check("mid_drop", drop_count, 0);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
